// File: rtl/kacc_pkg.sv
// Shared widths and types for the Karatsuba product accumulator.
package kacc_pkg;
  localparam int ACC_W  = 136;
  localparam int PROD_W = 128;
  localparam int CNT_W  = 9;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } tag_t;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
  } res_t;
endpackage

// File: rtl/kacc_result_fifo.sv
// Small result FIFO; the head entry is read straight out of the register file.
module kacc_result_fifo
  import kacc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  res_t din,
  output res_t dout,
  output logic full,
  output logic empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  res_t          mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= nxt(wptr);
      end
      if (do_pop) rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/kacc_product_accumulator.sv
// Sums multiplier products in groups of TERMS, with credit backpressure on issue.
// Optional KACC_LAST_EN adds issue_last for early group termination.
module kacc_product_accumulator
  import kacc_pkg::*;
#(
  parameter int MUL_LAT   = 8,
  parameter int TERMS     = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
`ifdef KACC_LAST_EN
  input  logic              issue_last,
`endif
  output logic              issue_ready,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CRW = $clog2(OUT_DEPTH + 1);

  logic [CNT_W-1:0] iidx;
  logic [CRW-1:0]   credits;
  logic             at_end, accept, closing, pop, push;
  tag_t             tag_in, tag_out;
  tag_t             tag_pipe [MUL_LAT:1];
  logic [ACC_W-1:0] acc, sum;
  logic             first;
  res_t             res_in, res_out;
  logic             fifo_full, fifo_empty;

  assign at_end = (iidx == CNT_W'(TERMS - 1));
  assign accept = issue_valid && issue_ready;

  // Credits are taken when a group closes at issue, so the FIFO slot is
  // reserved MUL_LAT cycles before the sum actually lands.
`ifdef KACC_LAST_EN
  assign issue_ready = !rst && (credits != '0);
  assign closing     = accept && (issue_last || at_end);
`else
  assign issue_ready = !rst && ((credits != '0) || !at_end);
  assign closing     = accept && at_end;
`endif

  assign tag_in  = '{valid: accept, last: closing, cnt: iidx + 1'b1};
  assign tag_out = tag_pipe[MUL_LAT];
  assign sum     = (first ? '0 : acc) + ACC_W'(prod);
  assign push    = tag_out.valid && tag_out.last;
  assign pop     = out_valid && out_ready;
  assign res_in  = '{sum: sum, cnt: tag_out.cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      iidx    <= '0;
      credits <= CRW'(OUT_DEPTH);
      acc     <= '0;
      first   <= 1'b1;
      for (int i = 1; i <= MUL_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      if (accept) iidx <= closing ? '0 : iidx + 1'b1;
      case ({closing, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
      tag_pipe[1] <= tag_in;
      for (int i = 2; i <= MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (tag_out.valid) begin
        acc   <= tag_out.last ? '0 : sum;
        first <= tag_out.last;
      end
    end
  end

  kacc_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (res_in),
    .dout  (res_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = res_out.sum;
  assign out_cnt   = res_out.cnt;

`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst) assert (!(push && fifo_full)) else $error("kacc: result push while FIFO full");
`endif
endmodule
